// File: rtl/chip8_pkg.sv
// Shared CHIP-8 definitions used by the sprite sequencer and its neighbours.
package chip8_pkg;

    // Display geometry and memory address width
    localparam int DISP_W = 64;
    localparam int DISP_H = 32;
    localparam int ADDR_W = 12;

    // Sprite sequencer states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAW  = 2'd2,
        S_DONE  = 2'd3
    } sprite_state_t;

endpackage

// File: rtl/chip8_sprite_sequencer.sv
// DXYN sprite-draw sequencer: fetches each sprite row from memory, holds it on
// the display interface for DRAW_HOLD cycles, ORs the per-row collision flags
// and returns VF with a done pulse.
// Optional build macro CHIP8_SPRITE_CLIP_EN: rows falling below the bottom
// edge of the display are skipped instead of wrapping to the top.
module chip8_sprite_sequencer
    import chip8_pkg::*;
#(
    parameter int DRAW_HOLD = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        vx,
    input  logic [7:0]        vy,
    input  logic [3:0]        n,
    input  logic [ADDR_W-1:0] i_reg,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic              draw,
    output logic [5:0]        x,
    output logic [4:0]        y,
    output logic [3:0]        row_index,
    output logic [7:0]        sprite_data,
    input  logic              collision,
    output logic              busy,
    output logic              done,
    output logic              vf_we,
    output logic [7:0]        vf_data
);

    localparam logic [3:0] HOLD_LAST = 4'(DRAW_HOLD - 1);

    sprite_state_t     state_reg;
    logic [3:0]        n_reg;
    logic [ADDR_W-1:0] i_base_reg;
    logic [3:0]        hold_cnt_reg;
    logic              coll_acc_reg;

    logic hold_last;
    logic last_row;
    logic next_row_off;
    logic coll_next;

    assign hold_last = (hold_cnt_reg == HOLD_LAST);
    assign last_row  = (row_index == (n_reg - 4'd1));
    assign coll_next = coll_acc_reg | collision;

`ifdef CHIP8_SPRITE_CLIP_EN
    // Row 0 always lands on screen because y is already reduced mod 32, so
    // only the row after the current one needs the off-screen test.
    logic [5:0] next_row_sum;
    assign next_row_sum = {1'b0, y} + {2'b0, row_index} + 6'd1;
    assign next_row_off = (next_row_sum >= 6'(DISP_H));
`else
    assign next_row_off = 1'b0;
`endif

    // Sequencer FSM with registered outputs and the row/hold counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            n_reg        <= '0;
            i_base_reg   <= '0;
            hold_cnt_reg <= '0;
            coll_acc_reg <= 1'b0;
            mem_req      <= 1'b0;
            mem_addr     <= '0;
            draw         <= 1'b0;
            x            <= '0;
            y            <= '0;
            row_index    <= '0;
            sprite_data  <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            vf_we        <= 1'b0;
            vf_data      <= '0;
        end else begin
            done  <= 1'b0;
            vf_we <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        x            <= vx[5:0];
                        y            <= vy[4:0];
                        n_reg        <= n;
                        i_base_reg   <= i_reg;
                        row_index    <= '0;
                        coll_acc_reg <= 1'b0;
                        busy         <= 1'b1;
                        if (n == 4'd0) begin
                            state_reg <= S_DONE;
                            done      <= 1'b1;
                            vf_we     <= 1'b1;
                            vf_data   <= 8'd0;
                        end else begin
                            state_reg <= S_FETCH;
                            mem_req   <= 1'b1;
                            mem_addr  <= i_reg;
                        end
                    end
                end
                S_FETCH: begin
                    if (mem_ack) begin
                        sprite_data  <= mem_rdata;
                        hold_cnt_reg <= '0;
                        mem_req      <= 1'b0;
                        draw         <= 1'b1;
                        state_reg    <= S_DRAW;
                    end
                end
                S_DRAW: begin
                    if (hold_last) begin
                        draw         <= 1'b0;
                        coll_acc_reg <= coll_next;
                        if (last_row || next_row_off) begin
                            state_reg <= S_DONE;
                            done      <= 1'b1;
                            vf_we     <= 1'b1;
                            vf_data   <= {7'b0, coll_next};
                        end else begin
                            row_index <= row_index + 4'd1;
                            mem_req   <= 1'b1;
                            mem_addr  <= i_base_reg + {{(ADDR_W-4){1'b0}}, row_index}
                                         + ADDR_W'(1);
                            state_reg <= S_FETCH;
                        end
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + 4'd1;
                    end
                end
                S_DONE: begin
                    busy      <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chip8_sprite_sequencer.sv
// Testbench for chip8_sprite_sequencer: directed scenarios plus randomized
// sprites, each checked cycle by cycle against a precomputed timeline model.
module tb_chip8_sprite_sequencer;

    localparam int H    = 3;
    localparam int MAXC = 512;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  vx = '0;
    logic [7:0]  vy = '0;
    logic [3:0]  n = '0;
    logic [11:0] i_reg = '0;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = '0;
    logic        collision = 1'b0;

    logic        mem_req;
    logic [11:0] mem_addr;
    logic        draw;
    logic [5:0]  x;
    logic [4:0]  y;
    logic [3:0]  row_index;
    logic [7:0]  sprite_data;
    logic        busy;
    logic        done;
    logic        vf_we;
    logic [7:0]  vf_data;

    chip8_sprite_sequencer #(.DRAW_HOLD(H)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vx(vx), .vy(vy), .n(n),
        .i_reg(i_reg), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .draw(draw), .x(x), .y(y),
        .row_index(row_index), .sprite_data(sprite_data),
        .collision(collision), .busy(busy), .done(done), .vf_we(vf_we),
        .vf_data(vf_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state: memory image and the expected cycle timeline
    logic [7:0]  mem [4096];
    logic [7:0]  t_vx, t_vy;
    logic [3:0]  t_n;
    logic [11:0] t_i;
    int          n_rows;
    int          total;
    int          draw_start [16];
    logic [11:0] row_addr [16];
    bit          coll     [MAXC];
    bit          exp_req  [MAXC];
    bit          exp_ack  [MAXC];
    bit          exp_draw [MAXC];
    logic [11:0] exp_addr [MAXC];
    int          exp_row  [MAXC];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_req"},     32'(mem_req),     32'd0);
        check({tag, "_mem_addr"},    32'(mem_addr),    32'd0);
        check({tag, "_draw"},        32'(draw),        32'd0);
        check({tag, "_x"},           32'(x),           32'd0);
        check({tag, "_y"},           32'(y),           32'd0);
        check({tag, "_row_index"},   32'(row_index),   32'd0);
        check({tag, "_sprite_data"}, 32'(sprite_data), 32'd0);
        check({tag, "_busy"},        32'(busy),        32'd0);
        check({tag, "_done"},        32'(done),        32'd0);
        check({tag, "_vf_we"},       32'(vf_we),       32'd0);
        check({tag, "_vf_data"},     32'(vf_data),     32'd0);
    endtask

    // Build the expected timeline: cycle 1 is the first cycle after start.
    // Each drawn row costs (wait+1) fetch cycles followed by H draw cycles,
    // and done lands on the cycle after the last draw cycle.
    task automatic build(input logic [7:0] bvx, input logic [7:0] bvy,
                         input logic [3:0] bn, input logic [11:0] bi,
                         input int minw, input int maxw, input bit rcoll);
        int c;
        int w;
        t_vx = bvx; t_vy = bvy; t_n = bn; t_i = bi;
        n_rows = int'(bn);
`ifdef CHIP8_SPRITE_CLIP_EN
        if (n_rows > 32 - int'(bvy % 8'd32)) n_rows = 32 - int'(bvy % 8'd32);
`endif
        for (int k = 0; k < MAXC; k++) begin
            coll[k]     = rcoll ? ($urandom_range(0, 5) == 0) : 1'b0;
            exp_req[k]  = 1'b0;
            exp_ack[k]  = 1'b0;
            exp_draw[k] = 1'b0;
            exp_addr[k] = '0;
            exp_row[k]  = 0;
        end
        c = 1;
        for (int r = 0; r < n_rows; r++) begin
            row_addr[r] = 12'(int'(bi) + r);
            w = int'($urandom_range(maxw, minw));
            for (int k = 0; k <= w; k++) begin
                exp_req[c]  = 1'b1;
                exp_ack[c]  = (k == w);
                exp_addr[c] = row_addr[r];
                c++;
            end
            draw_start[r] = c;
            for (int h = 0; h < H; h++) begin
                exp_draw[c] = 1'b1;
                exp_row[c]  = r;
                c++;
            end
        end
        total = c;
    endtask

    // Drive one transaction and compare every cycle against the timeline.
    // extra_at > 0 pulses a spurious start in that cycle; abort_at > 0
    // asserts reset in that cycle and ends the transaction there.
    task automatic run(input int extra_at, input int abort_at,
                       output int done_cyc, output int done_cnt);
        logic vf;
        vf = 1'b0;
        for (int r = 0; r < n_rows; r++) vf = vf | coll[draw_start[r] + H - 1];
        done_cyc = -1;
        done_cnt = 0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        start = 1'b1; vx = t_vx; vy = t_vy; n = t_n; i_reg = t_i;
        mem_ack = 1'b0; collision = coll[0];
        for (int c = 1; c <= total; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == abort_at) begin
                rst_n = 1'b0;
                mem_ack = 1'b0; collision = 1'b0;
                #1;
                check_all_zero("abort");
                repeat (3) begin
                    @(negedge clk);
                    check("abort_hold_done", 32'(done), 32'd0);
                end
                rst_n = 1'b1;
                repeat (4) begin
                    @(negedge clk);
                    check("after_abort_done", 32'(done), 32'd0);
                    check("after_abort_busy", 32'(busy), 32'd0);
                end
                return;
            end
            check("busy", 32'(busy), 32'd1);
            check("mem_req", 32'(mem_req), 32'(exp_req[c]));
            if (exp_req[c]) check("mem_addr", 32'(mem_addr), 32'(exp_addr[c]));
            check("draw", 32'(draw), 32'(exp_draw[c]));
            if (exp_draw[c]) begin
                check("x", 32'(x), 32'(t_vx[5:0]));
                check("y", 32'(y), 32'(t_vy[4:0]));
                check("row_index", 32'(row_index), 32'(exp_row[c]));
                check("sprite_data", 32'(sprite_data), 32'(mem[row_addr[exp_row[c]]]));
            end
            check("done", 32'(done), 32'(c == total));
            check("vf_we", 32'(vf_we), 32'(c == total));
            if (c == total) check("vf_data", 32'(vf_data), 32'(vf));
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (c == extra_at) begin
                start = 1'b1;
                vx = 8'($urandom); vy = 8'($urandom);
                n = 4'($urandom); i_reg = 12'($urandom);
            end
            mem_ack   = exp_ack[c];
            mem_rdata = exp_ack[c] ? mem[exp_addr[c]] : 8'($urandom);
            collision = coll[c];
        end
        @(negedge clk);
        start = 1'b0; mem_ack = 1'b0; collision = 1'b0;
        check("end_busy", 32'(busy), 32'd0);
        check("end_done", 32'(done), 32'd0);
        check("end_mem_req", 32'(mem_req), 32'd0);
        check("end_draw", 32'(draw), 32'd0);
        $display("sprite vx=%0d vy=%0d n=%0d i=0x%03h rows=%0d done_cycle=%0d vf=%0d",
                 t_vx, t_vy, t_n, t_i, n_rows, done_cyc, vf);
    endtask

    initial begin
        int dc, dn;
        for (int k = 0; k < 4096; k++) mem[k] = 8'($urandom);

        // Reset state
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single row
        mem[12'h200] = 8'hF0;
        build(8'd0, 8'd0, 4'd1, 12'h200, 0, 0, 1'b0);
        run(0, 0, dc, dn);
        check("single_done_cycle", 32'(dc), 32'd5);

        // Collision only in the last hold cycle of row 2; row 3 pulse early
        build(8'd10, 8'd3, 4'd5, 12'h300, 0, 0, 1'b0);
        coll[draw_start[2] + H - 1] = 1'b1;
        coll[draw_start[3]]         = 1'b1;
        run(0, 0, dc, dn);
        check("coll_vf_data", 32'(vf_data), 32'h01);
        check("coll_done_cycle", 32'(dc), 32'd21);

        // Pulse on a non-final hold cycle alone must not set VF
        build(8'd1, 8'd1, 4'd2, 12'h310, 0, 0, 1'b0);
        coll[draw_start[0]] = 1'b1;
        coll[draw_start[1] + 1] = 1'b1;
        run(0, 0, dc, dn);
        check("early_coll_vf_data", 32'(vf_data), 32'h00);

        // Memory wait states, operand wrap and address wrap
        build(8'd70, 8'd40, 4'd3, 12'hFFE, 2, 2, 1'b0);
        run(0, 0, dc, dn);
        check("wait_done_cycle", 32'(dc), 32'd19);

        // Empty sprite with a start pulse while busy
        build(8'd5, 8'd5, 4'd0, 12'h100, 0, 0, 1'b0);
        run(1, 0, dc, dn);
        check("empty_done_cycle", 32'(dc), 32'd1);
        check("empty_done_count", 32'(dn), 32'd1);
        check("empty_vf_data", 32'(vf_data), 32'd0);

        // Start pulse during a multi-row draw is dropped
        build(8'd9, 8'd9, 4'd3, 12'h150, 0, 1, 1'b1);
        run(4, 0, dc, dn);
        check("busy_start_done_count", 32'(dn), 32'd1);

        // Reset during DRAW of row 1, then a normal transaction
        build(8'd5, 8'd5, 4'd3, 12'h400, 0, 0, 1'b1);
        run(0, draw_start[1] + 1, dc, dn);
        check("abort_done_count", 32'(dn), 32'd0);
        build(8'd1, 8'd2, 4'd2, 12'h500, 0, 1, 1'b1);
        run(0, 0, dc, dn);
        check("post_abort_done_count", 32'(dn), 32'd1);

        // Bottom-edge behaviour
        build(8'd0, 8'd30, 4'd4, 12'h600, 0, 0, 1'b0);
        run(0, 0, dc, dn);
`ifdef CHIP8_SPRITE_CLIP_EN
        check("clip_done_cycle", 32'(dc), 32'd9);
`else
        check("clip_done_cycle", 32'(dc), 32'd17);
`endif

        // Randomized sprites
        for (int t = 0; t < 40; t++) begin
            int ex;
            build(8'($urandom), 8'($urandom), 4'($urandom), 12'($urandom),
                  0, 3, 1'b1);
            ex = ($urandom_range(0, 1) == 1) ? int'($urandom_range(total, 1)) : 0;
            run(ex, 0, dc, dn);
            check("rand_done_count", 32'(dn), 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
